fluxo_ram: RTL and testbench

Single-port synchronous RAM holding the 9-bit matrix words used by the matrix manager: two 5x5 operand matrices at addresses 0–49 and the 5x5 result matrix at 50–74.
- Read-only and write-only users each instantiate their own copy.
- After reset, an internal sweep loads a deterministic image before normal access is allowed.
- Reads are registered, with one-cycle latency.

---
 rtl/fluxo_ram.sv | 133 +++++++++++++
 tb/tb_fluxo_ram.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fluxo_ram.sv
// -----------------------------------------------------------------------------
// fluxo_ram
// Single-port synchronous RAM for the matrix manager's 9-bit words.
// Operand matrices live at addresses 0-49 and the result matrix at 50-74.
// After reset, an internal sweep writes a deterministic image into every word:
// word c holds c for c < PRELOAD_WORDS, and 0 above that. Normal access is
// allowed once the sweep completes and pronto is high.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   endereco      read/write address (ADDR_W bits)
//   dado_entrada  write data (DATA_W bits)
//   grava         write enable; 1 = write on this edge
//   dado_saida    registered read data, read-first, one-cycle latency
//   pronto        high once the init sweep is complete
// -----------------------------------------------------------------------------
module fluxo_ram #(
    parameter int DATA_W        = 9,
    parameter int ADDR_W        = 8,
    parameter int DEPTH         = 256,
    parameter int PRELOAD_WORDS = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] endereco,
    input  logic [DATA_W-1:0] dado_entrada,
    input  logic              grava,
    output logic [DATA_W-1:0] dado_saida,
    output logic              pronto
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Constants at the sweep counter's width so every compare is width-matched.
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C    = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PRELOAD_C = (ADDR_W+1)'(PRELOAD_WORDS);

    typedef enum logic {
        ST_SWEEP,
        ST_READY
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W:0]     sweep_cnt;     // one bit wider than the address so it can reach DEPTH
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                in_range;
    logic [DATA_W-1:0]   preload_word;
    logic                mem_we;
    logic [IDX_W-1:0]    mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    assign in_range = ({1'b0, endereco} < DEPTH_C);
    assign pronto   = (state == ST_READY);

    // -------------------------------------------------------------------------
    // Sweep control: state register plus counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_SWEEP) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        if (state == ST_SWEEP && sweep_cnt == LAST_C) begin
            state_nxt = ST_READY;   // last word written on this edge
        end
    end

    // -------------------------------------------------------------------------
    // Single write port: the sweep owns it until pronto, then the user does.
    // -------------------------------------------------------------------------
    always_comb begin
        preload_word = '0;
        if (sweep_cnt < PRELOAD_C) begin
            preload_word = DATA_W'(sweep_cnt);
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (state == ST_SWEEP) begin
            // Held off while rst_n is low so reset itself never touches the array.
            mem_we = rst_n;
            mem_wa = sweep_cnt[IDX_W-1:0];
            mem_wd = preload_word;
        end else if (grava && in_range) begin
            mem_we = 1'b1;
            mem_wa = endereco[IDX_W-1:0];
            mem_wd = dado_entrada;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM macros; its contents
    // are defined by the post-reset sweep instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // -------------------------------------------------------------------------
    // Registered read. The array write is non-blocking, so this samples the
    // word as it was before any write on the same edge (read-first).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dado_saida <= '0;
        end else if (state == ST_READY && in_range) begin
            dado_saida <= mem[endereco[IDX_W-1:0]];
        end else begin
            dado_saida <= '0;
        end
    end

endmodule

// File: tb/tb_fluxo_ram.sv
// -----------------------------------------------------------------------------
// tb_fluxo_ram
// Self-checking bench for fluxo_ram. Two instances share clk and rst_n:
//   dut_a : default build (DEPTH=256)
//   dut_b : DEPTH=64 build, for out-of-range behaviour and independence
// A plain array per instance models the memory; it is rebuilt from the
// preload rule after every completed sweep and updated on accepted writes.
// -----------------------------------------------------------------------------
module tb_fluxo_ram;

    logic       clk;
    logic       rst_n;

    logic [7:0] endereco;
    logic [8:0] dado_entrada;
    logic       grava;
    logic [8:0] dado_saida;
    logic       pronto;

    logic [7:0] endereco_b;
    logic [8:0] dado_entrada_b;
    logic       grava_b;
    logic [8:0] dado_saida_b;
    logic       pronto_b;

    int checks;
    int errors;

    logic [8:0] model_a [256];
    logic [8:0] model_b [64];

    fluxo_ram dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .endereco     (endereco),
        .dado_entrada (dado_entrada),
        .grava        (grava),
        .dado_saida   (dado_saida),
        .pronto       (pronto)
    );

    fluxo_ram #(.DEPTH(64)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .endereco     (endereco_b),
        .dado_entrada (dado_entrada_b),
        .grava        (grava_b),
        .dado_saida   (dado_saida_b),
        .pronto       (pronto_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image right after a completed sweep.
    task automatic load_models();
        for (int i = 0; i < 256; i++) model_a[i] = (i < 50) ? 9'(i) : 9'd0;
        for (int i = 0; i < 64; i++)  model_b[i] = (i < 50) ? 9'(i) : 9'd0;
    endtask

    // One access on dut_a: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic cyc_a(input logic [7:0] a, input logic [8:0] d, input logic w,
                         output logic [8:0] got);
        @(negedge clk);
        endereco = a; dado_entrada = d; grava = w;
        @(posedge clk);
        #1;
        got   = dado_saida;
        grava = 1'b0;
    endtask

    task automatic cyc_b(input logic [7:0] a, input logic [8:0] d, input logic w,
                         output logic [8:0] got);
        @(negedge clk);
        endereco_b = a; dado_entrada_b = d; grava_b = w;
        @(posedge clk);
        #1;
        got     = dado_saida_b;
        grava_b = 1'b0;
    endtask

    // Release reset and count rising edges through the whole sweep, hammering
    // both write ports with random traffic that must be ignored.
    task automatic sweep_and_count(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 256; e++) begin
            endereco     = 8'($urandom);
            dado_entrada = 9'($urandom);
            grava        = 1'($urandom);
            endereco_b     = 8'($urandom_range(0, 63));
            dado_entrada_b = 9'($urandom);
            grava_b        = (e <= 64) ? 1'($urandom) : 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (pronto !== (e >= 256)) begin
                errors++;
                $display("FAIL %s pronto_a edge %0d: got %b exp %b", tag, e, pronto, (e >= 256));
            end
            checks++;
            if (dado_saida !== 9'd0) begin
                errors++;
                $display("FAIL %s sweep_dout_a edge %0d: got %h exp 000", tag, e, dado_saida);
            end
            checks++;
            if (pronto_b !== (e >= 64)) begin
                errors++;
                $display("FAIL %s pronto_b edge %0d: got %b exp %b", tag, e, pronto_b, (e >= 64));
            end
            if (e <= 64) begin
                checks++;
                if (dado_saida_b !== 9'd0) begin
                    errors++;
                    $display("FAIL %s sweep_dout_b edge %0d: got %h exp 000", tag, e, dado_saida_b);
                end
            end
        end
        grava   = 1'b0;
        grava_b = 1'b0;
        load_models();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        endereco = '0; dado_entrada = '0; grava = 1'b0;
        endereco_b = '0; dado_entrada_b = '0; grava_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (pronto !== 1'b0)       begin errors++; $display("FAIL reset_pronto_a: got %b exp 0", pronto); end
        if (dado_saida !== 9'd0)   begin errors++; $display("FAIL reset_dout_a: got %h exp 000", dado_saida); end
        if (pronto_b !== 1'b0)     begin errors++; $display("FAIL reset_pronto_b: got %b exp 0", pronto_b); end
        if (dado_saida_b !== 9'd0) begin errors++; $display("FAIL reset_dout_b: got %h exp 000", dado_saida_b); end
        sweep_and_count("first_sweep");
    endtask

    task automatic test_preload_reads();
        logic [7:0] addrs [5];
        logic [8:0] got;
        addrs = '{8'd0, 8'd7, 8'd49, 8'd50, 8'd255};
        for (int i = 0; i < 5; i++) begin
            cyc_a(addrs[i], 9'd0, 1'b0, got);
            checks++;
            if (got !== model_a[addrs[i]]) begin
                errors++;
                $display("FAIL preload_read addr %0d: got %h exp %h", addrs[i], got, model_a[addrs[i]]);
            end
        end
    endtask

    task automatic test_read_first();
        logic [8:0] got;
        logic [8:0] exp;
        exp = model_a[60];
        cyc_a(8'd60, 9'h1FF, 1'b1, got);
        model_a[60] = 9'h1FF;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL read_first_old: got %h exp %h", got, exp);
        end
        cyc_a(8'd60, 9'd0, 1'b0, got);
        checks++;
        if (got !== 9'h1FF) begin
            errors++;
            $display("FAIL read_first_new: got %h exp 1ff", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got;
        logic [8:0] exp;
        for (int a = 50; a <= 74; a++) begin
            exp = model_a[a];
            cyc_a(8'(a), 9'h0AA, 1'b1, got);
            model_a[a] = 9'h0AA;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL burst_write addr %0d: got %h exp %h", a, got, exp);
            end
        end
        for (int a = 50; a <= 75; a++) begin
            cyc_a(8'(a), 9'd0, 1'b0, got);
            checks++;
            if (got !== model_a[a]) begin
                errors++;
                $display("FAIL burst_read addr %0d: got %h exp %h", a, got, model_a[a]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [8:0] d;
        logic       w;
        logic [8:0] got;
        logic [8:0] exp;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 9'($urandom);
            w = 1'($urandom);
            exp = model_a[a];
            cyc_a(a, d, w, got);
            if (w) model_a[a] = d;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random op %0d addr %0d we %b: got %h exp %h", i, a, w, got, exp);
            end
        end
    endtask

    task automatic test_mid_sweep_reset();
        logic [8:0] got;
        logic [7:0] addrs [4];
        // Make the output non-zero so an asynchronous clear is visible.
        cyc_a(8'd3, 9'h123, 1'b1, got);
        cyc_a(8'd3, 9'd0, 1'b0, got);
        checks++;
        if (got !== 9'h123) begin
            errors++;
            $display("FAIL pre_reset_read: got %h exp 123", got);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (pronto !== 1'b0)     begin errors++; $display("FAIL async_reset_pronto: got %b exp 0", pronto); end
        if (dado_saida !== 9'd0) begin errors++; $display("FAIL async_reset_dout: got %h exp 000", dado_saida); end

        // Run 100 sweep edges with writes attempted, then cut the sweep short.
        @(negedge clk);
        rst_n = 1'b1;
        endereco = 8'd3; dado_entrada = 9'h1FF; grava = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        grava = 1'b0;
        checks += 3;
        if (pronto !== 1'b0)       begin errors++; $display("FAIL mid_sweep_pronto_a: got %b exp 0", pronto); end
        if (dado_saida !== 9'd0)   begin errors++; $display("FAIL mid_sweep_dout_a: got %h exp 000", dado_saida); end
        if (pronto_b !== 1'b0)     begin errors++; $display("FAIL mid_sweep_pronto_b: got %b exp 0", pronto_b); end

        sweep_and_count("restart_sweep");

        addrs = '{8'd3, 8'd5, 8'd49, 8'd60};
        for (int i = 0; i < 4; i++) begin
            cyc_a(addrs[i], 9'd0, 1'b0, got);
            checks++;
            if (got !== model_a[addrs[i]]) begin
                errors++;
                $display("FAIL post_restart addr %0d: got %h exp %h", addrs[i], got, model_a[addrs[i]]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [8:0] got;
        cyc_b(8'd200, 9'h055, 1'b1, got);
        checks++;
        if (got !== 9'd0) begin errors++; $display("FAIL oor_write_cycle: got %h exp 000", got); end
        cyc_b(8'd200, 9'd0, 1'b0, got);
        checks++;
        if (got !== 9'd0) begin errors++; $display("FAIL oor_read: got %h exp 000", got); end
        cyc_b(8'd8, 9'd0, 1'b0, got);
        checks++;
        if (got !== model_b[8]) begin errors++; $display("FAIL no_wrap_addr8: got %h exp %h", got, model_b[8]); end

        // In-range traffic on the small build, and isolation from dut_a.
        cyc_b(8'd10, 9'h077, 1'b1, got);
        checks++;
        if (got !== model_b[10]) begin errors++; $display("FAIL b_write_old: got %h exp %h", got, model_b[10]); end
        model_b[10] = 9'h077;
        cyc_b(8'd10, 9'd0, 1'b0, got);
        checks++;
        if (got !== model_b[10]) begin errors++; $display("FAIL b_read_new: got %h exp %h", got, model_b[10]); end
        cyc_b(8'd63, 9'd0, 1'b0, got);
        checks++;
        if (got !== model_b[63]) begin errors++; $display("FAIL b_last_word: got %h exp %h", got, model_b[63]); end
        cyc_a(8'd10, 9'd0, 1'b0, got);
        checks++;
        if (got !== model_a[10]) begin errors++; $display("FAIL a_isolated: got %h exp %h", got, model_a[10]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_preload_reads();
        test_read_first();
        test_back_to_back();
        test_random();
        test_mid_sweep_reset();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
